// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_pkg
//  Description : Shared defaults, sequencer state encoding and beat layout
//                for the C = A x B operand index sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DIM_W_DEF  = 12;
    localparam int ADDR_W_DEF = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One operand-fetch beat as seen by the MAC datapath.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] a_addr;
        logic [ADDR_W_DEF-1:0] b_addr;
        logic [ADDR_W_DEF-1:0] c_addr;
        logic                  first_k;
        logic                  last_k;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/matmul_dim_check.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_dim_check
//  Description : Two-cycle legality checker for the launch dimensions.
//                Rejects zero dimensions, words with bits above DIM_W, and
//                any of M*K, K*N, M*N larger than 2^ADDR_W.
//                done_o pulses for one cycle, ok_o is valid with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_dim_check
    import matmul_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        launch_i,
    input  logic [31:0] a_rows_i,
    input  logic [31:0] a_cols_i,
    input  logic [31:0] b_cols_i,
    output logic        done_o,
    output logic        ok_o
);

    localparam int          PROD_W   = 2 * DIM_W;
    localparam logic [63:0] LIMIT    = 64'd1 << ADDR_W;
    localparam logic [1:0]  PH_IDLE  = 2'd0;
    localparam logic [1:0]  PH_MUL   = 2'd1;
    localparam logic [1:0]  PH_JUDGE = 2'd2;

    logic [1:0]        phase_q;
    logic              bad_q;
    logic [DIM_W-1:0]  m_q, k_q, n_q;
    logic [PROD_W-1:0] mk_q, kn_q, mn_q;

    // A word is unusable when its usable field is zero or it has stray upper bits.
    function automatic logic word_bad(input logic [31:0] w);
        return (w[DIM_W-1:0] == '0) || (w[31:DIM_W] != '0);
    endfunction

    // Latch on launch, register the three products, then judge them.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            bad_q   <= 1'b0;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            mk_q    <= '0;
            kn_q    <= '0;
            mn_q    <= '0;
        end else if (launch_i) begin
            phase_q <= PH_MUL;
            bad_q   <= word_bad(a_rows_i) | word_bad(a_cols_i) | word_bad(b_cols_i);
            m_q     <= a_rows_i[DIM_W-1:0];
            k_q     <= a_cols_i[DIM_W-1:0];
            n_q     <= b_cols_i[DIM_W-1:0];
        end else if (phase_q == PH_MUL) begin
            phase_q <= PH_JUDGE;
            mk_q    <= PROD_W'(m_q) * PROD_W'(k_q);
            kn_q    <= PROD_W'(k_q) * PROD_W'(n_q);
            mn_q    <= PROD_W'(m_q) * PROD_W'(n_q);
        end else if (phase_q == PH_JUDGE) begin
            phase_q <= PH_IDLE;
        end
    end

    assign done_o = (phase_q == PH_JUDGE);
    assign ok_o   = ~bad_q
                  & (64'(mk_q) <= LIMIT)
                  & (64'(kn_q) <= LIMIT)
                  & (64'(mn_q) <= LIMIT);

endmodule
`default_nettype wire

// File: rtl/matmul_index_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_index_seq
//  Description : Row-major triple-loop (i, j, k) operand address generator
//                for C = A x B with a valid/ready beat interface.
//                Addresses are stepped incrementally; no multipliers sit in
//                the beat path.
//                Optional macro MATMUL_SEQ_PERF_EN adds saturating
//                run_cycles_o / stall_cycles_o performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_index_seq
    import matmul_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       a_rows_i,
    input  logic [31:0]       a_cols_i,
    input  logic [31:0]       b_cols_i,
    input  logic              start_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic              first_k_o,
    output logic              last_k_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       run_cycles_o
`endif
);

    state_t            state_q;
    logic              start_q;
    logic [DIM_W-1:0]  i_q, j_q, k_q;
    logic [DIM_W-1:0]  m_last_q, n_last_q, k_last_q;
    logic [DIM_W-1:0]  k_dim_q, n_dim_q;
    logic [ADDR_W-1:0] row_base_q, a_q, b_q, c_q;
    logic              valid_q, first_q, last_q, busy_q, done_q, err_q;

    logic launch, fire, final_beat, chk_done, chk_ok;

    // Start edges only count while the sequencer is idle or finished.
    assign launch     = start_i & ~start_q & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign fire       = valid_q & out_ready_i;
    assign final_beat = (i_q == m_last_q) & (j_q == n_last_q) & (k_q == k_last_q);

    matmul_dim_check #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_dim_check (
        .clk      (clk),
        .reset    (reset),
        .launch_i (launch),
        .a_rows_i (a_rows_i),
        .a_cols_i (a_cols_i),
        .b_cols_i (b_cols_i),
        .done_o   (chk_done),
        .ok_o     (chk_ok)
    );

    // Sequencer FSM: launch, dimension check, beat stepping and completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            m_last_q   <= '0;
            n_last_q   <= '0;
            k_last_q   <= '0;
            k_dim_q    <= '0;
            n_dim_q    <= '0;
            row_base_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            start_q <= start_i;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state_q  <= S_CHECK;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        k_dim_q  <= a_cols_i[DIM_W-1:0];
                        n_dim_q  <= b_cols_i[DIM_W-1:0];
                        m_last_q <= a_rows_i[DIM_W-1:0] - DIM_W'(1);
                        k_last_q <= a_cols_i[DIM_W-1:0] - DIM_W'(1);
                        n_last_q <= b_cols_i[DIM_W-1:0] - DIM_W'(1);
                    end
                end
                S_CHECK: begin
                    if (chk_done) begin
                        if (chk_ok) begin
                            state_q    <= S_RUN;
                            busy_q     <= 1'b1;
                            valid_q    <= 1'b1;
                            i_q        <= '0;
                            j_q        <= '0;
                            k_q        <= '0;
                            row_base_q <= '0;
                            a_q        <= '0;
                            b_q        <= '0;
                            c_q        <= '0;
                            first_q    <= 1'b1;
                            last_q     <= (k_last_q == '0);
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (final_beat) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else if (k_q != k_last_q) begin
                            // Inner step: next A column, next B row.
                            k_q     <= k_q + DIM_W'(1);
                            a_q     <= a_q + ADDR_W'(1);
                            b_q     <= b_q + ADDR_W'(n_dim_q);
                            first_q <= 1'b0;
                            last_q  <= ((k_q + DIM_W'(1)) == k_last_q);
                        end else begin
                            // k wraps: a new C element starts.
                            k_q     <= '0;
                            c_q     <= c_q + ADDR_W'(1);
                            first_q <= 1'b1;
                            last_q  <= (k_last_q == '0);
                            if (j_q != n_last_q) begin
                                j_q <= j_q + DIM_W'(1);
                                a_q <= row_base_q;
                                b_q <= ADDR_W'(j_q) + ADDR_W'(1);
                            end else begin
                                j_q        <= '0;
                                i_q        <= i_q + DIM_W'(1);
                                row_base_q <= row_base_q + ADDR_W'(k_dim_q);
                                a_q        <= row_base_q + ADDR_W'(k_dim_q);
                                b_q        <= '0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = valid_q;
    assign a_addr_o    = a_q;
    assign b_addr_o    = b_q;
    assign c_addr_o    = c_q;
    assign first_k_o   = first_q;
    assign last_k_o    = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] run_q, stall_q;

    // Saturating RUN / stall counters, cleared on launch and held afterwards.
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            run_q   <= '0;
            stall_q <= '0;
        end else if (state_q == S_RUN) begin
            if (run_q != '1) begin
                run_q <= run_q + 32'd1;
            end
            if (valid_q && !out_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign run_cycles_o   = run_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_index_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_index_seq
//  Description : Self-checking bench for matmul_index_seq. A reference model
//                pushes expected beats into a scoreboard; a monitor compares
//                every presented beat against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_index_seq;
    import matmul_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_rows, a_cols, b_cols;
    logic        start, out_ready, out_valid;
    logic [ADDR_W_DEF-1:0] a_addr, b_addr, c_addr;
    logic        first_k, last_k, busy, done, err;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] stall_cycles, run_cycles;
`endif

    matmul_index_seq dut (
        .clk         (clk),
        .reset       (reset),
        .a_rows_i    (a_rows),
        .a_cols_i    (a_cols),
        .b_cols_i    (b_cols),
        .start_i     (start),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .a_addr_o    (a_addr),
        .b_addr_o    (b_addr),
        .c_addr_o    (c_addr),
        .first_k_o   (first_k),
        .last_k_o    (last_k),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .stall_cycles_o (stall_cycles),
        .run_cycles_o   (run_cycles)
`endif
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    beats_seen = 0;
    bit    mon_en = 1'b0;

    // Scoreboard monitor: every valid cycle must match the queue head.
    always @(negedge clk) begin
        beat_t got;
        if (mon_en && out_valid === 1'b1) begin
            got.a_addr  = a_addr;
            got.b_addr  = b_addr;
            got.c_addr  = c_addr;
            got.first_k = first_k;
            got.last_k  = last_k;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got a=%0d b=%0d c=%0d, required no beat",
                         a_addr, b_addr, c_addr);
            end else begin
                if (got !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL beat: got a=%0d b=%0d c=%0d fk=%0b lk=%0b, required a=%0d b=%0d c=%0d fk=%0b lk=%0b",
                             got.a_addr, got.b_addr, got.c_addr, got.first_k, got.last_k,
                             exp_q[0].a_addr, exp_q[0].b_addr, exp_q[0].c_addr,
                             exp_q[0].first_k, exp_q[0].last_k);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: direct products, independent of the incremental stepping.
    task automatic push_expected(input int m, input int k, input int n);
        beat_t e;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++) begin
                    e.a_addr  = ADDR_W_DEF'(i * k + kk);
                    e.b_addr  = ADDR_W_DEF'(kk * n + j);
                    e.c_addr  = ADDR_W_DEF'(i * n + j);
                    e.first_k = (kk == 0);
                    e.last_k  = (kk == k - 1);
                    exp_q.push_back(e);
                end
    endtask

    // Present dimensions and produce a clean 0->1 start edge.
    task automatic launch(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
        a_rows = m;
        a_cols = k;
        b_cols = n;
        start  = 1'b0;
        @(posedge clk); #1;
        start  = 1'b1;
    endtask

    // Drive out_ready until done rises (bounded); mode 1 gives ready 1,0,0,...
    task automatic drive_until_done(input int mode, input bit poke,
                                    output int stalls, output int hs,
                                    output int gap, output bit timed_out);
        int last_hs;
        stalls = 0; hs = 0; gap = -1; last_hs = -100; timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (done) begin
                timed_out = 1'b0;
                gap = c - last_hs;
                break;
            end
            out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (poke) begin
                if (c == 4) start = 1'b0;
                if (c == 6) begin
                    start  = 1'b1;
                    a_rows = 32'd7;
                    a_cols = 32'd9;
                    b_cols = 32'd5;
                end
            end
            if (out_valid && busy && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                hs++;
                last_hs = c;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        a_rows = 32'd0; a_cols = 32'd0; b_cols = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, busy, done, err, first_k, last_k, a_addr, b_addr, c_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b busy=%0b done=%0b err=%0b a=%0d b=%0d c=%0d, required all 0",
                     out_valid, busy, done, err, a_addr, b_addr, c_addr);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, busy, done, err} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got v=%0b busy=%0b done=%0b err=%0b, required 0000",
                     out_valid, busy, done, err);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        int st, hs, gap; bit to;
        push_expected(2, 3, 2);
        launch(32'd2, 32'd3, 32'd2);
        drive_until_done(0, 1'b0, st, hs, gap, to);
        n_cmp++;
        if (to || hs != 12) begin
            n_err++;
            $display("FAIL basic_count: got %0d beats timeout=%0b, required 12 beats", hs, to);
        end
        n_cmp++;
        if (gap != 1) begin
            n_err++;
            $display("FAIL basic_done_latency: got %0d cycles after last beat, required 1", gap);
        end
        n_cmp++;
        if ({done, err, busy, out_valid} !== 4'b1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_final: got done=%0b err=%0b busy=%0b v=%0b left=%0d, required 1000 left=0",
                     done, err, busy, out_valid, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int st, hs, gap; bit to;
        push_expected(2, 3, 2);
        launch(32'd2, 32'd3, 32'd2);
        drive_until_done(1, 1'b0, st, hs, gap, to);
        n_cmp++;
        if (to || hs != 12 || exp_q.size() != 0 || st == 0) begin
            n_err++;
            $display("FAIL stall_count: got %0d beats %0d stalls left=%0d timeout=%0b, required 12 beats, stalls>0, left=0",
                     hs, st, exp_q.size(), to);
        end
        out_ready = 1'b1;
`ifdef MATMUL_SEQ_PERF_EN
        n_cmp++;
        if (stall_cycles !== 32'(st)) begin
            n_err++;
            $display("FAIL perf_stall: got %0d, required %0d", stall_cycles, st);
        end
        n_cmp++;
        if (run_cycles !== 32'(12 + st)) begin
            n_err++;
            $display("FAIL perf_run: got %0d, required %0d", run_cycles, 12 + st);
        end
`endif
    endtask

    task automatic test_dim_error();
        int st, hs, gap; bit to;
        logic [31:0] dims [3][3];
        dims[0] = '{32'd2, 32'd0, 32'd2};
        dims[1] = '{32'h0000_1000, 32'd3, 32'd2};
        dims[2] = '{32'd1025, 32'd1024, 32'd1};
        for (int t = 0; t < 3; t++) begin
            launch(dims[t][0], dims[t][1], dims[t][2]);
            drive_until_done(0, 1'b0, st, hs, gap, to);
            n_cmp++;
            if (to || hs != 0 || {done, err, busy, out_valid} !== 4'b1100) begin
                n_err++;
                $display("FAIL dim_error_%0d: got beats=%0d done=%0b err=%0b busy=%0b v=%0b timeout=%0b, required 0 beats 1100",
                         t, hs, done, err, busy, out_valid, to);
            end
        end
    endtask

    task automatic test_single();
        int st, hs, gap; bit to;
        push_expected(1, 1, 1);
        launch(32'd1, 32'd1, 32'd1);
        drive_until_done(0, 1'b0, st, hs, gap, to);
        n_cmp++;
        if (to || hs != 1 || {done, err} !== 2'b10 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single: got beats=%0d done=%0b err=%0b timeout=%0b, required 1 beat done=1 err=0",
                     hs, done, err, to);
        end
    endtask

    task automatic test_relaunch();
        int st, hs, gap; bit to; bit bad;
        push_expected(2, 3, 2);
        launch(32'd2, 32'd3, 32'd2);
        drive_until_done(0, 1'b1, st, hs, gap, to);
        n_cmp++;
        if (to || hs != 12 || exp_q.size() != 0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL relaunch_ignored: got beats=%0d left=%0d done=%0b, required 12 beats left=0 done=1",
                     hs, exp_q.size(), done);
        end
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL start_held: got relaunch activity v=%0b done=%0b, required v=0 done=1", out_valid, done);
        end
        push_expected(1, 2, 1);
        launch(32'd1, 32'd2, 32'd1);
        @(posedge clk); #1;
        n_cmp++;
        if ({done, err} !== 2'b00) begin
            n_err++;
            $display("FAIL relaunch_clear: got done=%0b err=%0b, required 00", done, err);
        end
        drive_until_done(0, 1'b0, st, hs, gap, to);
        n_cmp++;
        if (to || hs != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL relaunch_run: got beats=%0d left=%0d, required 2 left=0", hs, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int st, hs, gap; bit to; bit hit;
        push_expected(2, 3, 2);
        beats_seen = 0;
        hit = 1'b0;
        launch(32'd2, 32'd3, 32'd2);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (beats_seen == 5) begin
                out_ready = 1'b0;
                reset     = 1'b1;
                hit       = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        n_cmp++;
        if (!hit || {out_valid, busy, done, err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_abort: got reached=%0b v=%0b busy=%0b done=%0b err=%0b, required reached=1 0000",
                     hit, out_valid, busy, done, err);
        end
        out_ready = 1'b1;
        push_expected(2, 3, 2);
        launch(32'd2, 32'd3, 32'd2);
        drive_until_done(0, 1'b0, st, hs, gap, to);
        n_cmp++;
        if (to || hs != 12 || exp_q.size() != 0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rerun: got beats=%0d left=%0d done=%0b, required 12 left=0 done=1",
                     hs, exp_q.size(), done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_dim_error();
        test_single();
        test_relaunch();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_index_seq.md
Name: matmul_index_seq

Overview:
Consumes the matrix-dimension words held by the HPS-facing PIO registers (A_rows, A_cols, B_cols) and a start bit from the control PIO. Generates the row-major triple-loop operand address stream for C = A x B. Each beat carries A, B and C buffer addresses plus k-boundary flags, and is delivered to the MAC datapath over a valid/ready handshake. Sits directly downstream of the dimension PIOs and upstream of the operand buffer read ports.

Parameters:
DIM_W, 12, usable bits per dimension; PIO words with nonzero bits above DIM_W are rejected.
ADDR_W, 20, width of a_addr, b_addr and c_addr.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
a_rows  in  32  A row count (from PIO out_port)
a_cols  in  32  A column count = inner dimension K
b_cols  in  32  B column count
start  in  1  level from control PIO; a rising edge launches a run
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
a_addr  out  ADDR_W  i*K + k
b_addr  out  ADDR_W  k*b_cols + j
c_addr  out  ADDR_W  i*b_cols + j
first_k  out  1  beat has k==0 (clear accumulator)
last_k  out  1  beat has k==K-1 (write C)
busy  out  1  state RUN
done  out  1  sticky completion flag, cleared by next accepted start
err  out  1  sticky dimension error, cleared by next accepted start

Behaviour:
- Reset: state IDLE. out_valid, busy, done, err, first_k and last_k are 0. All addresses and counters are 0. start edge register is 0.
- Start detection: start_q registers start. Launch = start & ~start_q. Edges seen outside IDLE/DONE are ignored; no queueing.
- On launch: latch M=a_rows, K=a_cols, N=b_cols into DIM_W registers and clear done/err.
  - If any of the three is zero, any upper bits [31:DIM_W] are set, or M*K, K*N or M*N exceeds 2^ADDR_W: set err and go to DONE next cycle with no beats. Product check is done once at launch, multi-cycle allowed (≤3 cycles in a CHECK state).
- States: IDLE -> CHECK on launch. CHECK -> RUN if dims are legal, else DONE. RUN -> DONE after the final beat handshake. DONE -> CHECK on launch.
- RUN: out_valid=1 continuously. A beat transfers when out_valid & out_ready.
  - With out_ready=0, every output stays stable (AXI-style hold).
  - First beat appears the cycle after entering RUN. Throughput is 1 beat/cycle.
- Loop order: i outer (0..M-1), j middle (0..N-1), k inner (0..K-1). Total beats M*N*K.
- Addresses are updated incrementally; no multipliers in the beat path:
  - k advance: a_addr+1, b_addr+N.
  - k wrap with j advance: a_addr=row_base, b_addr=j+1.
  - k and j wrap: row_base+=K, a_addr=row_base+K, b_addr=0.
  - c_addr increments by 1 on every k wrap.
- first_k = (k==0). last_k = (k==K-1). When K=1, both are high on every beat.
- Final beat (i=M-1, j=N-1, k=K-1) handshake: next cycle out_valid=0, busy=0, done=1, state DONE.
- Synchronous reset asserted mid-RUN aborts the run immediately and returns every output to its reset value. No partial done is reported.
- Changes to the PIO inputs during RUN have no effect, since the dimensions are latched.

Optional Feature:
MATMUL_SEQ_PERF_EN:
- Defined: adds outputs stall_cycles[31:0] and run_cycles[31:0].
  - Both are cleared on launch.
  - run_cycles counts cycles in RUN; stall_cycles counts RUN cycles with out_valid & ~out_ready.
  - Both saturate at 0xFFFFFFFF and are held after DONE for HPS readback.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package matmul_pkg:
  - DIM_W and ADDR_W defaults.
  - state enum {IDLE, CHECK, RUN, DONE}.
  - beat struct {a_addr, b_addr, c_addr, first_k, last_k}.
- One natural sub-module, matmul_dim_check: the multi-cycle legality/product-overflow checker used in CHECK.
- Loop counters and address stepping stay in the top module.

Test Plan:
- Dims M=2, K=3, N=2, start edge, out_ready=1 -> 12 beats.
  - a_addr = 0,1,2, 0,1,2, 3,4,5, 3,4,5.
  - b_addr = 0,2,4, 1,3,5, 0,2,4, 1,3,5.
  - c_addr = 0,0,0, 1,1,1, 2,2,2, 3,3,3.
  - first_k on beats 0,3,6,9; last_k on beats 2,5,8,11; done=1 one cycle after beat 11.
- Same dims with out_ready toggling 1,0,0,1,... -> identical sequence; outputs held during every stall. With PERF: stall_cycles equals the number of ready-low RUN cycles.
- a_cols=0, or a_rows=0x00001000 with DIM_W=12 -> err=1, done=1, zero beats, out_valid never high.
- M=1, K=1, N=1 -> single beat, a/b/c_addr=0, first_k=last_k=1, then done.
- Start edge during RUN, and start held high across DONE -> no relaunch. A new 0->1 edge from DONE clears done/err and restarts at addr 0.
- reset pulsed at beat 5 of the 2x3x2 run -> out_valid=0, busy=0, done=0 next cycle; a fresh start reproduces the full 12-beat sequence.
